// File: rtl/result_mailbox.sv
// End-of-test mailbox on the core data bus: FLAG/RESULT registers, a run-cycle
// counter and a sticky watchdog that fires if no completion flag arrives in time.
module result_mailbox #(
  parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 100,
  parameter int          CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_enable_i,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  input  logic [31:0]      data_addr_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_wdata_i,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic [31:0]      mem_flag_o,
  output logic [31:0]      mem_result_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             timeout_o
);

  // state   | meaning
  // IDLE    | waiting for fetch_enable_i, counter held at 0
  // RUN     | counting cycles, watching for a nonzero FLAG write
  // DONE    | completion flag seen; terminal until reset
  // TIMEOUT | watchdog expired; terminal until reset
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      flag_reg;
  logic [31:0]      result_reg;
  logic [31:0]      rdata_reg;
  logic             rvalid_reg;
  logic             err_reg;

  logic        hit;
  logic [1:0]  off;
  logic        wr_ok;
  logic        flag_wr;
  logic        result_wr;
  logic        acc_err;
  logic [31:0] flag_next;
  logic [31:0] result_next;
  logic [31:0] cycles_ext;
  logic [31:0] status;
  logic [31:0] rd_val;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^data_addr_i[1:0];

  assign hit       = (data_addr_i[31:4] == BASE_ADDR[31:4]);
  assign off       = data_addr_i[3:2];
  assign wr_ok     = (state == ST_IDLE) || (state == ST_RUN);
  assign flag_wr   = data_req_i && data_we_i && hit && (off == 2'd0) && wr_ok;
  assign result_wr = data_req_i && data_we_i && hit && (off == 2'd1) && wr_ok;
  // Read-only registers report an error on write; terminal-state writes to FLAG/RESULT do not.
  assign acc_err   = data_req_i && (!hit || (data_we_i && off[1]));

  always_comb begin
    flag_next   = flag_reg;
    result_next = result_reg;
    for (int i = 0; i < 4; i++) begin
      if (data_be_i[i]) begin
        flag_next[8*i +: 8]   = data_wdata_i[8*i +: 8];
        result_next[8*i +: 8] = data_wdata_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    cycles_ext             = '0;
    cycles_ext[CNT_W-1:0]  = cnt;
  end

  assign status  = {28'd0, state, (state == ST_TIMEOUT), (state == ST_DONE)};
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_ONE;

  always_comb begin
    case (off)
      2'd0:    rd_val = flag_reg;
      2'd1:    rd_val = result_reg;
      2'd2:    rd_val = cycles_ext;
      default: rd_val = status;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      flag_reg   <= '0;
      result_reg <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= data_req_i;
      err_reg    <= acc_err;
      rdata_reg  <= (data_req_i && !data_we_i && !acc_err) ? rd_val : 32'd0;
      if (flag_wr)   flag_reg   <= flag_next;
      if (result_wr) result_reg <= result_next;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fetch_enable_i) state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= cnt_inc;
          // A completing FLAG write beats a watchdog expiry on the same edge.
          if (flag_wr && (flag_next != 32'd0)) state <= ST_DONE;
          else if (cnt_inc >= TIMEOUT_CNT)     state <= ST_TIMEOUT;
        end
        default: state <= state;
      endcase
    end
  end

  assign data_gnt_o    = data_req_i;
  assign data_rvalid_o = rvalid_reg;
  assign data_rdata_o  = rdata_reg;
  assign data_err_o    = err_reg;
  assign mem_flag_o    = flag_reg;
  assign mem_result_o  = result_reg;
  assign cycles_o      = cnt;
  assign timeout_o     = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_result_mailbox.sv
// Bench for result_mailbox: directed scenarios plus random bus traffic, all
// outputs compared every cycle against a behavioural model of the mailbox.
module tb_result_mailbox;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        gnt, rvalid, err, timeout;
  logic [31:0] rdata, flag, result, cycles;

  int total = 0;
  int bad = 0;

  result_mailbox #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fetch),
    .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rdata_o(rdata), .data_err_o(err),
    .mem_flag_o(flag), .mem_result_o(result), .cycles_o(cycles), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 running, 2 done, 3 timed out.
  int          m_phase = 0;
  logic [31:0] m_cnt = 0, m_flag = 0, m_result = 0, m_rdata = 0;
  logic        m_rvalid = 0, m_err = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_flag = 0; m_result = 0;
      m_rdata = 0; m_rvalid = 0; m_err = 0;
    end else begin
      bit          in_win, writable, flag_hit;
      int          reg_idx;
      logic [31:0] read_val, new_flag;
      in_win   = (addr >= BASE) && (addr < BASE + 32'd16);
      reg_idx  = int'((addr - BASE) / 4);
      writable = (m_phase <= 1);
      flag_hit = 0;
      new_flag = m_flag;
      case (reg_idx)
        0: read_val = m_flag;
        1: read_val = m_result;
        2: read_val = m_cnt;
        default: read_val = (m_phase * 4) + (m_phase == 3 ? 2 : 0) + (m_phase == 2 ? 1 : 0);
      endcase
      m_rvalid = req;
      m_err    = req && (!in_win || (we && reg_idx >= 2));
      m_rdata  = (req && !we && in_win) ? read_val : 32'd0;
      if (req && we && in_win && writable) begin
        if (reg_idx == 0) begin new_flag = merge(m_flag, wdata, be); flag_hit = 1; end
        if (reg_idx == 1) m_result = merge(m_result, wdata, be);
      end
      if (m_phase == 0) begin
        if (fetch) m_phase = 1;
      end else if (m_phase == 1) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (flag_hit && new_flag != 0) m_phase = 2;
        else if (m_cnt >= TMO)         m_phase = 3;
      end
      m_flag = new_flag;
    end
  end

  always @(negedge clk) begin
    chk("gnt", {31'd0, gnt}, {31'd0, req});
    chk("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("rdata", rdata, m_rdata);
    chk("flag", flag, m_flag);
    chk("result", result, m_result);
    chk("cycles", cycles, m_cnt);
    chk("timeout", {31'd0, timeout}, (m_phase == 3) ? 32'd1 : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    req = 0; we = 0; be = 0; addr = 0; wdata = 0;
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d);
    req = 1; addr = a; we = w; be = b; wdata = d;
    tick();
    idle_bus();
  endtask

  task automatic rand_bus();
    int sel;
    req = ($urandom_range(3) != 0);
    we  = $urandom_range(1);
    be  = 4'($urandom_range(15));
    sel = $urandom_range(7);
    if (sel <= 5)      addr = BASE + $urandom_range(15);
    else if (sel == 6) addr = BASE + 32'h20 + $urandom_range(15);
    else               addr = $urandom;
    // Keep most FLAG writes zero so runs last long enough to exercise the counter.
    if (addr[31:4] == BASE[31:4] && addr[3:2] == 2'd0 && $urandom_range(15) != 0) wdata = 0;
    else wdata = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 0; fetch = 0;
    for (int i = 0; i < 3; i++) begin rand_bus(); tick(); end
    idle_bus();
    rst_n = 1;
  endtask

  task automatic start_run();
    fetch = 1;
    tick();
    fetch = 0;
  endtask

  initial begin
    // T1: reset with traffic
    #1 rst_n = 0;
    for (int i = 0; i < 4; i++) begin rand_bus(); tick(); end
    chk("t1_flag", flag, 32'd0);
    chk("t1_cycles", cycles, 32'd0);
    chk("t1_rvalid", {31'd0, rvalid}, 32'd0);
    idle_bus();
    rst_n = 1;
    access(BASE + 32'hC, 0, 4'hF, 0);
    chk("t1_status", rdata, 32'd0);
    chk("t1_status_valid", {31'd0, rvalid}, 32'd1);

    // T2: normal end
    do_reset();
    start_run();
    access(BASE + 32'h4, 1, 4'hF, 32'd55);
    access(BASE + 32'h0, 1, 4'hF, 32'd1);
    chk("t2_result", result, 32'd55);
    chk("t2_flag", flag, 32'd1);
    chk("t2_cycles", cycles, 32'd2);
    access(BASE + 32'hC, 0, 4'hF, 0);
    chk("t2_status", rdata, 32'h9);
    access(BASE + 32'h0, 1, 4'hF, 32'd0);
    chk("t2_late_wr_err", {31'd0, err}, 32'd0);
    access(BASE + 32'h4, 1, 4'hF, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_flag_kept", flag, 32'd1);
    chk("t2_result_kept", result, 32'd55);
    chk("t2_cycles_frozen", cycles, 32'd2);

    // T3: watchdog
    do_reset();
    start_run();
    for (int i = 0; i < 300 && !timeout; i++) tick();
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_cycles", cycles, 32'd100);
    access(BASE + 32'h0, 1, 4'hF, 32'd1);
    chk("t3_flag_ignored", flag, 32'd0);
    access(BASE + 32'hC, 0, 4'hF, 0);
    chk("t3_status", rdata, 32'hE);

    // T4: flag write on the expiry edge
    do_reset();
    start_run();
    for (int i = 0; i < 300 && cycles != 32'd99; i++) tick();
    chk("t4_wait99", cycles, 32'd99);
    access(BASE + 32'h0, 1, 4'hF, 32'd1);
    chk("t4_timeout", {31'd0, timeout}, 32'd0);
    chk("t4_flag", flag, 32'd1);
    chk("t4_cycles", cycles, 32'd100);
    access(BASE + 32'hC, 0, 4'hF, 0);
    chk("t4_status", rdata, 32'h9);

    // T5: byte enables and errors
    do_reset();
    access(BASE + 32'h4, 1, 4'hF, 32'hAABB_CCDD);
    access(BASE + 32'h4, 1, 4'b0010, 32'h0000_1100);
    chk("t5_merge", result, 32'hAABB_11DD);
    access(BASE + 32'h7, 0, 4'hF, 0);
    chk("t5_read_result", rdata, 32'hAABB_11DD);
    access(BASE + 32'h20, 0, 4'hF, 0);
    chk("t5_oob_valid", {31'd0, rvalid}, 32'd1);
    chk("t5_oob_err", {31'd0, err}, 32'd1);
    chk("t5_oob_rdata", rdata, 32'd0);
    access(BASE + 32'h8, 1, 4'hF, 32'h1234_5678);
    chk("t5_ro_err", {31'd0, err}, 32'd1);
    chk("t5_ro_cycles", cycles, 32'd0);

    // T6: reset mid-run during an access
    do_reset();
    start_run();
    for (int i = 0; i < 100 && cycles != 32'd40; i++) tick();
    chk("t6_wait40", cycles, 32'd40);
    req = 1; addr = BASE + 32'h4; we = 0; be = 4'hF;
    #2 rst_n = 0;
    #1;
    chk("t6_cycles", cycles, 32'd0);
    tick();
    chk("t6_rvalid", {31'd0, rvalid}, 32'd0);
    idle_bus();
    rst_n = 1;
    access(BASE + 32'hC, 0, 4'hF, 0);
    chk("t6_status", rdata, 32'd0);

    // Random episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        fetch = (c > 3) ? 1'($urandom_range(1)) : 1'b0;
        rand_bus();
        tick();
      end
      idle_bus();
      fetch = 0;
    end
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
